// File: rtl/cache_line_refill_engine_if.sv
// Bundle of cache-side, line-buffer and ddr_controller burst signals for the refill engine.
// The master modport is the engine's view; slave is the cache/controller side.
interface cache_line_refill_engine_if #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int BEAT_W         = 3
);
  logic                      ddr_ready;
  logic                      miss_req;
  logic [DDR_ADDR_WIDTH-1:0] miss_addr;
  logic                      wb_dirty;
  logic [DDR_ADDR_WIDTH-1:0] wb_addr;
  logic                      miss_ack;
  logic                      busy;
  logic                      done;
  logic                      err;

  logic                      lb_rd_en;
  logic [BEAT_W-1:0]         lb_rd_idx;
  logic [DDR_DATA_WIDTH-1:0] lb_rd_data;
  logic                      lb_wr_en;
  logic [BEAT_W-1:0]         lb_wr_idx;
  logic [DDR_DATA_WIDTH-1:0] lb_wr_data;

  logic                      rd_burst_req;
  logic [9:0]                rd_burst_len;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
  logic                      rd_burst_data_valid;
  logic [DDR_DATA_WIDTH-1:0] rd_burst_data;
  logic                      rd_burst_finish;

  logic                      wr_burst_req;
  logic [9:0]                wr_burst_len;
  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr;
  logic                      wr_burst_data_req;
  logic [DDR_DATA_WIDTH-1:0] wr_burst_data;
  logic                      wr_burst_finish;

  modport master (
    input  ddr_ready, miss_req, miss_addr, wb_dirty, wb_addr,
    output miss_ack, busy, done, err,
    output lb_rd_en, lb_rd_idx,
    input  lb_rd_data,
    output lb_wr_en, lb_wr_idx, lb_wr_data,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    output wr_burst_req, wr_burst_len, wr_burst_addr,
    input  wr_burst_data_req, wr_burst_finish,
    output wr_burst_data
  );

  modport slave (
    output ddr_ready, miss_req, miss_addr, wb_dirty, wb_addr,
    input  miss_ack, busy, done, err,
    input  lb_rd_en, lb_rd_idx,
    output lb_rd_data,
    input  lb_wr_en, lb_wr_idx, lb_wr_data,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    input  wr_burst_req, wr_burst_len, wr_burst_addr,
    output wr_burst_data_req, wr_burst_finish,
    input  wr_burst_data
  );
endinterface

// File: rtl/cache_line_refill_engine.sv
// Miss/writeback sequencer: optional victim write burst from the line buffer,
// then a read burst refilling the line buffer, one request at a time.
module cache_line_refill_engine #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int BEAT_W         = 3
) (
  input logic                       clk,
  input logic                       rst_n,
  cache_line_refill_engine_if.master bus
);
  localparam int BURST_LEN = 1 << BEAT_W;
  localparam int CNT_W     = BEAT_W + 1;
  localparam int LOW_W     = BEAT_W + 3;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{BEAT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURST_LEN);
  // Line-aligned addresses: the controller advances by 8 per beat itself.
  localparam logic [DDR_ADDR_WIDTH-1:0] ADDR_MASK =
    ~((DDR_ADDR_WIDTH'(1) << LOW_W) - DDR_ADDR_WIDTH'(1));

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_REQ  = 3'd1,
    S_WB_DATA = 3'd2,
    S_WB_WAIT = 3'd3,
    S_RF_REQ  = 3'd4,
    S_RF_DATA = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DDR_ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic [DDR_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic                      err_q, err_d;
  logic                      ack_q, ack_d;
  logic                      rd_vld_q, rd_vld_d;
  logic                      lb_rd_en_s;
  logic                      lb_wr_en_s;
  logic                      wb_phase_s;
  logic                      rf_phase_s;

  assign wb_phase_s = (state_q == S_WB_REQ) || (state_q == S_WB_DATA);
  assign rf_phase_s = (state_q == S_RF_REQ) || (state_q == S_RF_DATA);

  // State, beat counter, latched addresses and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      miss_addr_q <= {DDR_ADDR_WIDTH{1'b0}};
      wb_addr_q   <= {DDR_ADDR_WIDTH{1'b0}};
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_addr_q <= miss_addr_d;
      wb_addr_q   <= wb_addr_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  // Next-state, beat accounting and line-buffer strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    miss_addr_d = miss_addr_q;
    wb_addr_d   = wb_addr_q;
    err_d       = err_q;
    ack_d       = 1'b0;
    lb_rd_en_s  = 1'b0;
    lb_wr_en_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.miss_req && bus.ddr_ready) begin
          miss_addr_d = bus.miss_addr & ADDR_MASK;
          wb_addr_d   = bus.wb_addr & ADDR_MASK;
          ack_d       = 1'b1;
          err_d       = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = bus.wb_dirty ? S_WB_REQ : S_RF_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WB_REQ, S_WB_DATA: begin
        if (bus.wr_burst_data_req) begin
          lb_rd_en_s = 1'b1;
          cnt_d      = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        // A finish that arrives with the last beat is a clean completion.
        if (bus.wr_burst_finish) begin
          if (!(bus.wr_burst_data_req && (cnt_q == CNT_LAST))) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_RF_REQ;
        end else if (bus.wr_burst_data_req) begin
          state_d = (cnt_q == CNT_LAST) ? S_WB_WAIT : S_WB_DATA;
        end else begin
          state_d = state_q;
        end
      end

      S_WB_WAIT: begin
        if (bus.wr_burst_finish) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_RF_REQ;
        end else if (bus.wr_burst_data_req) begin
          err_d = 1'b1;
        end else begin
          state_d = S_WB_WAIT;
        end
      end

      S_RF_REQ, S_RF_DATA: begin
        if (bus.rd_burst_data_valid) begin
          if (cnt_q < CNT_FULL) begin
            lb_wr_en_s = 1'b1;
            cnt_d      = cnt_q + CNT_ONE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
        if (bus.rd_burst_finish) begin
          if (cnt_d < CNT_FULL) begin
            err_d = 1'b1;
          end else begin
            err_d = err_d | 1'b0;
          end
          state_d = S_DONE;
        end else if (bus.rd_burst_data_valid) begin
          state_d = S_RF_DATA;
        end else begin
          state_d = state_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_vld_d = lb_rd_en_s;
  end

  assign bus.miss_ack      = ack_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.err           = err_q;

  assign bus.wr_burst_req  = (state_q == S_WB_REQ);
  assign bus.wr_burst_len  = 10'(BURST_LEN);
  assign bus.wr_burst_addr = wb_addr_q;
  // Buffer data lands one cycle after the read, lined up with the controller's write enable.
  assign bus.wr_burst_data = rd_vld_q ? bus.lb_rd_data : {DDR_DATA_WIDTH{1'b0}};
  assign bus.lb_rd_en      = lb_rd_en_s;
  assign bus.lb_rd_idx     = wb_phase_s ? cnt_q[BEAT_W-1:0] : {BEAT_W{1'b0}};

  assign bus.rd_burst_req  = (state_q == S_RF_REQ);
  assign bus.rd_burst_len  = 10'(BURST_LEN);
  assign bus.rd_burst_addr = miss_addr_q;
  assign bus.lb_wr_en      = lb_wr_en_s;
  assign bus.lb_wr_idx     = rf_phase_s ? cnt_q[BEAT_W-1:0] : {BEAT_W{1'b0}};
  assign bus.lb_wr_data    = rf_phase_s ? bus.rd_burst_data : {DDR_DATA_WIDTH{1'b0}};
endmodule

// File: tb/tb_cache_line_refill_engine.sv
// Directed bench for cache_line_refill_engine with a small controller/line-buffer model
// and scoreboards for write-burst data and line-buffer refill writes.
module tb_cache_line_refill_engine;
  localparam int DW = 128;
  localparam int AW = 28;
  localparam int BW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cache_line_refill_engine_if #(.DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .BEAT_W(BW)) bus ();

  cache_line_refill_engine #(.DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .BEAT_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [DW-1:0]    lb_mem [8];
  logic [131:0]     sb_wd [$];
  logic [131:0]     sb_wr [$];
  logic [131:0]     exp_wd;
  logic [131:0]     exp_wr;
  logic             wd_pend;

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Line buffer read port, one cycle latency.
  always @(posedge clk) begin
    if (bus.lb_rd_en) bus.lb_rd_data <= lb_mem[bus.lb_rd_idx];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_pend <= 1'b0;
    else        wd_pend <= bus.wr_burst_data_req;
  end

  // Scoreboard pops: write data one cycle after each data request, refill writes same cycle.
  always @(negedge clk) begin
    if (rst_n && wd_pend) begin
      chk("wd_sb_nonempty", 132'(sb_wd.size() > 0), 132'(1));
      if (sb_wd.size() > 0) begin
        exp_wd = sb_wd.pop_front();
        chk("wr_burst_data", 132'(bus.wr_burst_data), exp_wd);
      end
    end
    if (bus.lb_wr_en) begin
      chk("wr_sb_nonempty", 132'(sb_wr.size() > 0), 132'(1));
      if (sb_wr.size() > 0) begin
        exp_wr = sb_wr.pop_front();
        chk("lb_wr_idx_data", {1'b0, bus.lb_wr_idx, bus.lb_wr_data}, exp_wr);
      end
    end
  end

  task automatic all_zero(input string tag);
    chk({tag, "_busy"},     132'(bus.busy), 132'(0));
    chk({tag, "_err"},      132'(bus.err), 132'(0));
    chk({tag, "_ack"},      132'(bus.miss_ack), 132'(0));
    chk({tag, "_done"},     132'(bus.done), 132'(0));
    chk({tag, "_rdreq"},    132'(bus.rd_burst_req), 132'(0));
    chk({tag, "_wrreq"},    132'(bus.wr_burst_req), 132'(0));
    chk({tag, "_lbrden"},   132'(bus.lb_rd_en), 132'(0));
    chk({tag, "_lbwren"},   132'(bus.lb_wr_en), 132'(0));
    chk({tag, "_rdaddr"},   132'(bus.rd_burst_addr), 132'(0));
    chk({tag, "_wraddr"},   132'(bus.wr_burst_addr), 132'(0));
    chk({tag, "_wrdata"},   132'(bus.wr_burst_data), 132'(0));
    chk({tag, "_lbwrdata"}, 132'(bus.lb_wr_data), 132'(0));
    chk({tag, "_rdlen"},    132'(bus.rd_burst_len), 132'(8));
    chk({tag, "_wrlen"},    132'(bus.wr_burst_len), 132'(8));
  endtask

  // Raise a miss and wait (bounded) for the acknowledge cycle.
  task automatic accept(input logic [AW-1:0] ma, input logic dirty, input logic [AW-1:0] wa);
    int n;
    cyc();
    bus.ddr_ready = 1'b1;
    bus.miss_addr = ma;
    bus.wb_dirty  = dirty;
    bus.wb_addr   = wa;
    bus.miss_req  = 1'b1;
    @(negedge clk);
    n = 0;
    while (!bus.miss_ack && n < 20) begin
      cyc();
      @(negedge clk);
      n++;
    end
    chk("miss_ack", 132'(bus.miss_ack), 132'(1));
    chk("ack_busy", 132'(bus.busy), 132'(1));
    chk("ack_err_clear", 132'(bus.err), 132'(0));
  endtask

  // Controller side of a write burst; gap of 3 idle cycles after beat gap_after (<0: none).
  task automatic writeback(input int gap_after, input logic [AW-1:0] rd_addr);
    int   beat;
    int   gap;
    logic req;
    beat = 0;
    gap  = 0;
    cyc();
    bus.miss_req = 1'b0;
    @(negedge clk);
    chk("wb_req_hold", 132'(bus.wr_burst_req), 132'(1));
    chk("wb_rden_idle", 132'(bus.lb_rd_en), 132'(0));
    while (beat < 8) begin
      cyc();
      if (gap_after >= 0 && beat == gap_after + 1 && gap < 3) begin
        req = 1'b0;
        gap++;
      end else begin
        req = 1'b1;
      end
      bus.wr_burst_data_req = req;
      if (req) sb_wd.push_back(132'(8'hA0 + beat));
      @(negedge clk);
      chk("rd_req_during_wb", 132'(bus.rd_burst_req), 132'(0));
      if (req) begin
        chk("lb_rd_en", 132'(bus.lb_rd_en), 132'(1));
        chk("lb_rd_idx", 132'(bus.lb_rd_idx), 132'(beat));
        chk("wr_req_drop", 132'(bus.wr_burst_req), 132'(beat == 0));
        beat++;
      end else begin
        chk("lb_rd_en_gap", 132'(bus.lb_rd_en), 132'(0));
      end
    end
    cyc();
    bus.wr_burst_data_req = 1'b0;
    @(negedge clk);
    chk("wb_wait_rdreq", 132'(bus.rd_burst_req), 132'(0));
    cyc();
    bus.wr_burst_finish = 1'b1;
    @(negedge clk);
    chk("wb_fin_rdreq", 132'(bus.rd_burst_req), 132'(0));
    cyc();
    bus.wr_burst_finish = 1'b0;
    @(negedge clk);
    chk("rd_req_after_wbfin", 132'(bus.rd_burst_req), 132'(1));
    chk("rd_addr_dirty", 132'(bus.rd_burst_addr), 132'(rd_addr));
  endtask

  // Controller side of a read burst of nbeats, then finish; checks done/err timing.
  task automatic refill(input int nbeats, input int base, input logic exp_err);
    for (int b = 0; b < nbeats; b++) begin
      cyc();
      bus.rd_burst_data_valid = 1'b1;
      bus.rd_burst_data       = DW'(base + b);
      if (b < 8) sb_wr.push_back({1'b0, 3'(b), DW'(base + b)});
      @(negedge clk);
      chk("rd_req_until_valid", 132'(bus.rd_burst_req), 132'(b == 0));
      chk("no_ack_busy", 132'(bus.miss_ack), 132'(0));
      if (b >= 8) chk("lb_wr_en_drop", 132'(bus.lb_wr_en), 132'(0));
    end
    cyc();
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_finish     = 1'b1;
    @(negedge clk);
    chk("done_not_yet", 132'(bus.done), 132'(0));
    cyc();
    bus.rd_burst_finish = 1'b0;
    @(negedge clk);
    chk("done_pulse", 132'(bus.done), 132'(1));
    chk("done_err", 132'(bus.err), 132'(exp_err));
    chk("done_busy", 132'(bus.busy), 132'(1));
    cyc();
    @(negedge clk);
    chk("idle_busy", 132'(bus.busy), 132'(0));
    chk("idle_done", 132'(bus.done), 132'(0));
    chk("idle_ack", 132'(bus.miss_ack), 132'(0));
    chk("idle_err_sticky", 132'(bus.err), 132'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) lb_mem[i] = DW'(8'hA0 + i);
    bus.ddr_ready = 1'b0;
    bus.miss_req = 1'b0;
    bus.miss_addr = '0;
    bus.wb_dirty = 1'b0;
    bus.wb_addr = '0;
    bus.lb_rd_data = '0;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data = '0;
    bus.rd_burst_finish = 1'b0;
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish = 1'b0;

    #12;
    all_zero("reset");
    cyc();
    rst_n = 1'b1;

    // Request blocked while calibration incomplete.
    cyc();
    bus.miss_addr = 28'h0000123;
    bus.miss_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("not_ready_ack", 132'(bus.miss_ack), 132'(0));
      chk("not_ready_busy", 132'(bus.busy), 132'(0));
    end

    // Clean miss.
    accept(28'h0000123, 1'b0, 28'h0);
    chk("clean_rdreq", 132'(bus.rd_burst_req), 132'(1));
    chk("clean_wrreq", 132'(bus.wr_burst_req), 132'(0));
    chk("clean_rdaddr", 132'(bus.rd_burst_addr), 132'(28'h0000100));
    chk("clean_rdlen", 132'(bus.rd_burst_len), 132'(8));
    cyc();
    bus.miss_req = 1'b0;
    @(negedge clk);
    chk("rd_req_hold", 132'(bus.rd_burst_req), 132'(1));
    refill(8, 0, 1'b0);

    // Dirty miss, back-to-back data requests.
    accept(28'h0000400, 1'b1, 28'h0000240);
    chk("dirty_wrreq", 132'(bus.wr_burst_req), 132'(1));
    chk("dirty_rdreq", 132'(bus.rd_burst_req), 132'(0));
    chk("dirty_wraddr", 132'(bus.wr_burst_addr), 132'(28'h0000240));
    writeback(-1, 28'h0000400);
    refill(8, 16, 1'b0);

    // Dirty miss with a 3-cycle data-request gap after beat 3.
    accept(28'h00007FF, 1'b1, 28'h000027F);
    chk("gap_wraddr", 132'(bus.wr_burst_addr), 132'(28'h0000240));
    writeback(3, 28'h00007C0);
    refill(8, 32, 1'b0);

    // Short burst; a second request held meanwhile is acked only after done.
    accept(28'h0000880, 1'b0, 28'h0);
    cyc();
    bus.miss_addr = 28'h00003C5;
    bus.miss_req  = 1'b1;
    @(negedge clk);
    chk("held_no_ack", 132'(bus.miss_ack), 132'(0));
    refill(5, 80, 1'b1);
    cyc();
    @(negedge clk);
    chk("held_ack", 132'(bus.miss_ack), 132'(1));
    chk("held_rdaddr", 132'(bus.rd_burst_addr), 132'(28'h00003C0));
    chk("held_err_clear", 132'(bus.err), 132'(0));
    cyc();
    bus.miss_req = 1'b0;
    @(negedge clk);
    chk("held_rdreq", 132'(bus.rd_burst_req), 132'(1));
    refill(9, 96, 1'b1);

    // Reset in the middle of a refill.
    accept(28'h0000A00, 1'b0, 28'h0);
    cyc();
    bus.miss_req = 1'b0;
    for (int b = 0; b < 3; b++) begin
      cyc();
      bus.rd_burst_data_valid = 1'b1;
      bus.rd_burst_data       = DW'(112 + b);
      sb_wr.push_back({1'b0, 3'(b), DW'(112 + b)});
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("midrst");
    cyc();
    bus.rd_burst_data_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 132'(bus.busy), 132'(0));
    accept(28'h0000555, 1'b0, 28'h0);
    chk("post_rst_rdaddr", 132'(bus.rd_burst_addr), 132'(28'h0000540));
    cyc();
    bus.miss_req = 1'b0;
    @(negedge clk);
    refill(8, 128, 1'b0);

    chk("sb_wd_empty", 132'(sb_wd.size()), 132'(0));
    chk("sb_wr_empty", 132'(sb_wr.size()), 132'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
